// File: rtl/lcd_ctrl_n.sv
// HD44780-style LCD write controller: power-on init sequence, configuration
// writes, then single-word writes from a valid/ready request port.
module lcd_ctrl_n #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BUS_WIDTH  = 8,
    parameter int LINES      = 2,
    parameter int T_POWER_US = 15000
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic [8:0] d_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [7:0] d,
    output logic       busy_flag,
    output logic       init_done
);

    function automatic int cyc_ns(input longint t_ns);
        longint c;
        c = (t_ns * longint'(CLK_FREQ) + longint'(999999999)) / longint'(1000000000);
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CYC_PW   = cyc_ns(longint'(T_POWER_US) * 1000);
    localparam int CYC_SU   = cyc_ns(60);
    localparam int CYC_EN   = cyc_ns(450);
    localparam int CYC_GAP  = max2(cyc_ns(1000), CYC_SU);
    localparam int CYC_4M1  = cyc_ns(4100000);
    localparam int CYC_100U = cyc_ns(100000);
    localparam int CYC_40U  = cyc_ns(40000);
    localparam int CYC_2M   = cyc_ns(2000000);
    localparam int CNT_MAX  = max2(CYC_PW, max2(CYC_4M1, CYC_2M));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // Terminal counts; the power wait also absorbs the partial cycle before
    // the first edge after reset release.
    localparam logic [CNT_W-1:0] L_PW   = CNT_W'(CYC_PW);
    localparam logic [CNT_W-1:0] L_SU   = CNT_W'(CYC_SU - 1);
    localparam logic [CNT_W-1:0] L_EN   = CNT_W'(CYC_EN - 1);
    localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(CYC_GAP - 1);
    localparam logic [CNT_W-1:0] L_4M1  = CNT_W'(CYC_4M1 - 1);
    localparam logic [CNT_W-1:0] L_100U = CNT_W'(CYC_100U - 1);
    localparam logic [CNT_W-1:0] L_40U  = CNT_W'(CYC_40U - 1);
    localparam logic [CNT_W-1:0] L_2M   = CNT_W'(CYC_2M - 1);

    localparam logic       FOUR_BIT = (BUS_WIDTH == 4);
    localparam logic [7:0] FUNC_SET = {3'b001, (BUS_WIDTH == 8), (LINES == 2), 3'b000};
    localparam logic [3:0] LAST_STEP = 4'd8;

    typedef enum logic [2:0] {ST_POWER, ST_SETUP, ST_PULSE, ST_WAIT, ST_IDLE} state_t;

    typedef struct packed {
        logic [7:0]       b;
        logic             nib;
        logic [CNT_W-1:0] term;
    } step_t;

    function automatic step_t step_info(input logic [3:0] idx);
        step_t s;
        s.b    = 8'h30;
        s.nib  = 1'b1;
        s.term = L_100U;
        case (idx)
            4'd0:    s.term = L_4M1;
            4'd3:    s.b = 8'h20;
            4'd4:    begin s.b = FUNC_SET; s.nib = 1'b0; s.term = L_40U; end
            4'd5:    begin s.b = 8'h08;    s.nib = 1'b0; s.term = L_40U; end
            4'd6:    begin s.b = 8'h01;    s.nib = 1'b0; s.term = L_2M;  end
            4'd7:    begin s.b = 8'h06;    s.nib = 1'b0; s.term = L_40U; end
            4'd8:    begin s.b = 8'h0C;    s.nib = 1'b0; s.term = L_40U; end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] bus_val(input logic [7:0] b, input logic low);
        if (!FOUR_BIT) return b;
        return low ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, term_q, term_d;
    logic [3:0]       step_q, step_d, ld_idx;
    logic [7:0]       byte_q, byte_d, d_q, d_d;
    logic             rs_q, rs_d, e_q, e_d, ready_q, ready_d, init_done_q, init_done_d;
    logic             nib_q, nib_d, low_q, low_d, user_q, user_d, ld_step;
    step_t            info;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        term_d      = term_q;
        step_d      = step_q;
        byte_d      = byte_q;
        d_d         = d_q;
        rs_d        = rs_q;
        e_d         = 1'b0;
        init_done_d = init_done_q;
        nib_d       = nib_q;
        low_d       = low_q;
        user_d      = user_q;
        ld_step     = 1'b0;
        ld_idx      = 4'd0;

        case (state_q)
            ST_POWER: begin
                if (cnt_q == L_PW) ld_step = 1'b1;
            end
            ST_SETUP: begin
                if (cnt_q == (low_q ? L_GAP : L_SU)) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                    e_d     = 1'b1;
                end
            end
            ST_PULSE: begin
                e_d = 1'b1;
                if (cnt_q == L_EN) begin
                    e_d   = 1'b0;
                    cnt_d = '0;
                    // The low nibble's setup overlaps the inter-nibble e-low gap.
                    if (FOUR_BIT && !nib_q && !low_q) begin
                        low_d   = 1'b1;
                        d_d     = bus_val(byte_q, 1'b1);
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == term_q) begin
                    cnt_d = '0;
                    if (user_q || step_q == LAST_STEP) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        ld_step = 1'b1;
                        ld_idx  = (step_q == 4'd2 && !FOUR_BIT) ? 4'd4 : step_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (data_valid) begin
                    byte_d  = d_in[7:0];
                    rs_d    = d_in[8];
                    user_d  = 1'b1;
                    nib_d   = 1'b0;
                    low_d   = 1'b0;
                    term_d  = (!d_in[8] && d_in[7:2] == 6'd0 && d_in[1:0] != 2'd0) ? L_2M : L_40U;
                    d_d     = bus_val(d_in[7:0], 1'b0);
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_POWER;
        endcase

        info = step_info(ld_idx);
        if (ld_step) begin
            step_d  = ld_idx;
            byte_d  = info.b;
            rs_d    = 1'b0;
            nib_d   = FOUR_BIT & info.nib;
            low_d   = 1'b0;
            user_d  = 1'b0;
            term_d  = info.term;
            d_d     = bus_val(info.b, 1'b0);
            cnt_d   = '0;
            state_d = ST_SETUP;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            state_q     <= ST_POWER;
            cnt_q       <= '0;
            term_q      <= '0;
            step_q      <= 4'd0;
            byte_q      <= 8'h00;
            d_q         <= 8'h00;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            nib_q       <= 1'b0;
            low_q       <= 1'b0;
            user_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            term_q      <= term_d;
            step_q      <= step_d;
            byte_q      <= byte_d;
            d_q         <= d_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            nib_q       <= nib_d;
            low_q       <= low_d;
            user_q      <= user_d;
        end
    end

    assign data_ready = ready_q;
    assign busy_flag  = ~ready_q;
    assign rs         = rs_q;
    assign rw         = 1'b0;
    assign e          = e_q;
    assign d          = d_q;
    assign init_done  = init_done_q;

endmodule

// File: doc/lcd_ctrl_n.md
LCD_CTRL_N -- requirements
Module: lcd_ctrl_n

Interface
REQ-001 Parameters: CLK_FREQ, default 50000000, clock frequency in Hz; BUS_WIDTH, default 8, LCD data bus width, 4 or 8; LINES, default 2, display lines, 1 or 2; T_POWER_US, default 15000, power-on wait in us.
REQ-002 Ports (clock and reset first):
- clock, input, 1, sole clock; all logic rising-edge.
- internal_reset_n, input, 1, reset; asynchronous, active-low.
- d_in, input, 9, bit 8 = RS, bits 7:0 = byte.
- data_valid, input, 1, request to write d_in.
- data_ready, output, 1, block accepts d_in this cycle.
- rs, output, 1, LCD register select.
- rw, output, 1, LCD read/write; constant 0.
- e, output, 1, LCD enable strobe.
- d, output, 8, LCD data; in 4-bit mode nibbles on d[7:4], d[3:0]=0.
- busy_flag, output, 1, high whenever data_ready is low.
- init_done, output, 1, sticky high after the init sequence completes.

Function
REQ-003 Delay unit: cyc(t) = max(1, ceil(t*CLK_FREQ)), computed at elaboration; the shared down/up counter is wide enough for cyc(T_POWER_US).
REQ-004 Bus write of one transfer: d/rs stable for cyc(60ns), then e=1 for cyc(450ns), then e=0. d/rs held unchanged until the next transfer's setup begins.
REQ-005 Byte write: 8-bit mode is one transfer of the byte. 4-bit mode is the upper nibble transfer, e=0 for cyc(1us), then the lower nibble transfer.
REQ-006 Init FSM, in order:
- POWER_WAIT: cyc(T_POWER_US us).
- 0x30 write, wait cyc(4.1ms).
- 0x30 write, wait cyc(100us).
- 0x30 write, wait cyc(100us).
- 4-bit mode only: 0x20 write, wait cyc(100us).
- In 4-bit mode, each of the four preceding writes is a single upper-nibble transfer.
REQ-007 Configuration writes follow, each a full byte write:
- Function set {3'b001, BUS_WIDTH==8, LINES==2, 3'b000}, wait cyc(40us).
- Display off 0x08, wait cyc(40us).
- Clear 0x01, wait cyc(2ms).
- Entry mode 0x06, wait cyc(40us).
- Display on 0x0C, wait cyc(40us).
- Then set init_done=1 and enter IDLE.
REQ-008 rs=0 for all init writes.
REQ-009 IDLE: data_ready=1, busy_flag=0. All other states: data_ready=0, busy_flag=1.
REQ-010 Acceptance: data_valid=1 and data_ready=1 at a rising edge captures d_in; data_ready drops the next cycle. Later changes to d_in or data_valid are ignored until the next acceptance.
REQ-011 Accepted word: rs=d_in[8], byte=d_in[7:0], written per REQ-004/005.
REQ-012 Post-write wait, then return to IDLE:
- cyc(2ms) if rs=0 and byte[7:2]=0 (clear/home, i.e. byte in 0x01..0x03).
- Otherwise cyc(40us).
REQ-013 data_valid asserted during init or busy states is not accepted and not queued.
REQ-014 Back-to-back: with data_valid held high, the next word is accepted on the first cycle data_ready=1. No idle gap beyond one cycle is required.
REQ-015 Byte 0x00 with rs=0 is written as an ordinary command with the 40us wait.

Reset
REQ-016 internal_reset_n=0 asynchronously forces:
- e=0, rs=0, rw=0, d=0x00.
- data_ready=0, busy_flag=1, init_done=0.
- counter=0, FSM=POWER_WAIT.
REQ-017 Reset mid-write or mid-wait aborts immediately; e falls within reset assertion. After release the full init sequence restarts from POWER_WAIT.
REQ-018 The first rising edge after release counts as cycle 1 of POWER_WAIT.

Verification (CLK_FREQ=1000000, so cyc(t)=ceil(t in us), min 1)
REQ-019 Bench: BUS_WIDTH=8, LINES=2, reset release.
- Exactly these e pulses with rs=0: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C.
- First e rise at cycle 15001+1.
- init_done rises after the final 40-cycle wait.
REQ-020 Bench: BUS_WIDTH=4, LINES=1.
- Init nibbles on d[7:4]: 3, 3, 3, 2.
- Then byte pairs 2/0, 0/8, 0/1, 0/6, 0/C.
- d[3:0]=0 throughout.
- Inter-nibble e-low gap = 1 cycle.
REQ-021 Bench: after init, write d_in=0x141 with a 1-cycle data_valid.
- rs=1, d=0x41.
- One e pulse, 1 cycle wide.
- data_ready returns 40 cycles after e falls.
REQ-022 Bench: write d_in=0x001, then 0x002, then 0x010.
- Post-write waits: 2000, 2000, 40 cycles.
- data_valid held high: each word accepted on the first data_ready cycle.
REQ-023 Bench: data_valid pulsed during init with d_in=0x155.
- No e pulse carries 0x55.
- data_ready=0 throughout.
REQ-024 Bench: internal_reset_n pulsed low while e=1 during a user write.
- e=0 and d=0x00 immediately.
- busy_flag=1, init_done=0.
- Full init repeats per REQ-019.
